alp_seq_controller: RTL and testbench
=====================================

# alp_seq_controller

Parametrised, self-sequencing control unit for the N-bit arithmetic logic processor. It replaces the externally counted T-step controller with an internal step counter and a comp/busy/done handshake. It adds restoring division on the previously unused opcode 011 and sizes the Booth multiply loop from N. It drives the register-file write/select lines, the ALU operand/op selects and the Acc/Q/E control lines of the datapath.

## Interface
- N, 4: operand width; MUL and DIV each run N iterations
- CNT_W, $clog2(N+1): width of the iteration counter (derived, not overridden)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- comp  in  1  start request; sampled only in IDLE
- op  in  3  opcode: 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100/101/110 logic ops, 111 ALU op 011
- load, clr  in  1  register-file load / clear requests (IDLE only, below comp)
- E  in  1  Booth E bit (Q-1)
- q0  in  1  Q[0]
- acc_neg  in  1  Acc sign after trial subtract
- b_zero  in  1  divisor register is zero
- we0, we1  out  1  register-file write enables
- src0, src1  out  2  write-data selects: 00 zero, 01 ALU, 10 external, 11 Acc/Q
- alusrcA, alusrcB  out  2  ALU operand selects
- alucntl  out  3  ALU function
- AccSrc, QSrc, AccCntl, Qcntl  out  1  Acc/Q load and shift controls
- shl  out  1  shift direction: 1 = left (DIV), 0 = right (MUL)
- enable  out  1  load ALU result into Acc
- reset_e  out  1  clear E
- qset  out  1  shift 1 into Q[0] (DIV quotient bit)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  DIV by zero; valid with done

## Operation
- Outputs are decoded combinationally from state. In ARITH and DIV_CHK they also depend on q0/E/acc_neg. Any output not listed for a state is 0.
- While rst=1, all outputs are forced to 0. On the next edge: state = IDLE, counter = 0.
- IDLE. Priority is comp > load > clr:
  - comp: latch op, then go to EXEC (ALU ops), MUL_INIT, DIV_INIT, or DONE with err=1 if op=011 and b_zero=1.
  - load: go to LDW, which drives src0=src1=10, we0=we1=1 for one cycle.
  - clr: go to CLW, which drives src0=src1=00, we0=we1=1 for one cycle.
  - LDW and CLW return to IDLE.
- ALU ops:
  - EXEC: alusrcA=alusrcB=01, alucntl from the op map.
  - WB: alucntl held, src0=01, src1=00, we0=we1=1.
  - Then DONE.
- MUL (Booth):
  - MUL_INIT: AccSrc=0, AccCntl=Qcntl=QSrc=1, reset_e=1; counter=N.
  - ARITH: alusrcA=10, enable=1. {q0,E}=10 selects alusrcB=01, alucntl=001. {q0,E}=01 selects alusrcB=01, alucntl=000. Otherwise alusrcB=00, alucntl=000.
  - SHIFT: AccSrc=1, QSrc=0, AccCntl=Qcntl=1, shl=0; counter decrements. Go to ARITH while the counter is nonzero after the decrement, else to MWB.
  - MWB: src0=src1=11, we0=we1=1; then DONE.
- DIV (restoring, unsigned):
  - DIV_INIT: as MUL_INIT; counter=N.
  - DSHIFT: as SHIFT with shl=1.
  - DSUB: alusrcA=10, alusrcB=01, alucntl=001, enable=1.
  - DIV_CHK: if acc_neg=1, restore with alusrcA=10, alusrcB=01, alucntl=000, enable=1. Otherwise qset=1. Counter decrements; go to DSHIFT or MWB.
  - Result: reg0 = remainder, reg1 = quotient.
- DONE: done=1 and err as set; go to IDLE. err clears on leaving DONE.
- comp during busy is ignored. comp held high restarts an operation from IDLE.

## Timing
- Latency from the comp-sampling edge to the done cycle:
  - ALU ops: 3 cycles.
  - MUL: 2N+3 cycles.
  - DIV: 3N+3 cycles.
  - DIV by zero: 1 cycle.
- Register writes occur only in WB, MWB, LDW and CLW, exactly one cycle each.
- rst asserted mid-operation: no write or done is issued in the rst cycle; the next cycle is IDLE.
- Counter never wraps: it is loaded with N and decrements only in SHIFT or DIV_CHK.

## Test plan
- N=4, op=000, comp pulse: EXEC (alucntl=000), WB (we0=we1=1, src0=01), done at cycle 3; op=111 drives alucntl=011.
- N=4, MUL with q0/E sequence 10,11,01,00: ARITH selects alucntl 001/000/000/000 and alusrcB 01/00/01/00; MWB at cycle 2N+2; done at 11.
- N=8, DIV with acc_neg pattern 1,0,0,1,0,0,0,1: qset in 5 DIV_CHK cycles, restore in 3; done at cycle 27.
- DIV with b_zero=1: done=err=1 one cycle after the start edge; no we0/we1 ever asserted.
- In IDLE, comp=load=clr=1: comp wins. Then load+clr: LDW (src=10). Then clr alone: CLW (src=00).
- rst during the MUL SHIFT state: outputs 0 that cycle, busy=0 next cycle, no done; a new comp starts cleanly.

Source files
------------

// File: rtl/alp_seq_controller_if.sv
// Control/status bundle between the ALP sequence controller and the datapath it steers.
// The datapath side (master) drives requests and flags; the controller (slave) drives control lines.
interface alp_seq_controller_if;
  logic       comp;
  logic [2:0] op;
  logic       load;
  logic       clr;
  logic       E;
  logic       q0;
  logic       acc_neg;
  logic       b_zero;

  logic       we0;
  logic       we1;
  logic [1:0] src0;
  logic [1:0] src1;
  logic [1:0] alusrcA;
  logic [1:0] alusrcB;
  logic [2:0] alucntl;
  logic       AccSrc;
  logic       QSrc;
  logic       AccCntl;
  logic       Qcntl;
  logic       shl;
  logic       enable;
  logic       reset_e;
  logic       qset;
  logic       busy;
  logic       done;
  logic       err;

  // comp is a level request: it is taken when the controller is idle (busy=0) and ignored while busy=1.
  // done pulses for exactly one cycle per accepted operation; err is meaningful only while done=1.
  modport master (
    output comp, op, load, clr, E, q0, acc_neg, b_zero,
    input  we0, we1, src0, src1, alusrcA, alusrcB, alucntl,
           AccSrc, QSrc, AccCntl, Qcntl, shl, enable, reset_e, qset,
           busy, done, err
  );

  modport slave (
    input  comp, op, load, clr, E, q0, acc_neg, b_zero,
    output we0, we1, src0, src1, alusrcA, alusrcB, alucntl,
           AccSrc, QSrc, AccCntl, Qcntl, shl, enable, reset_e, qset,
           busy, done, err
  );
endinterface

// File: rtl/alp_seq_controller.sv
// Self-sequencing controller for the N-bit ALP: ALU ops, Booth multiply and restoring divide.
// All control lines are decoded combinationally from the current state (plus q0/E/acc_neg).
module alp_seq_controller #(
  parameter  int N     = 4,
  localparam int CNT_W = $clog2(N + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  alp_seq_controller_if.slave  bus,
  output logic [3:0]           o_state
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_EXEC     = 4'd1,
    S_WB       = 4'd2,
    S_MUL_INIT = 4'd3,
    S_ARITH    = 4'd4,
    S_SHIFT    = 4'd5,
    S_DIV_INIT = 4'd6,
    S_DSHIFT   = 4'd7,
    S_DSUB     = 4'd8,
    S_DIV_CHK  = 4'd9,
    S_MWB      = 4'd10,
    S_DONE     = 4'd11,
    S_LDW      = 4'd12,
    S_CLW      = 4'd13
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_op;
  logic             r_err;
  logic [2:0]       w_alu;
  logic             w_last;

  assign o_state = r_state;
  assign w_alu   = (r_op == 3'b111) ? 3'b011 : r_op;
  // The decrement happens in the same cycle, so "last iteration" is a count of one.
  assign w_last  = (r_cnt == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE) begin
        if (bus.comp) r_op <= bus.op;
        r_err <= bus.comp && (bus.op == 3'b011) && bus.b_zero;
      end else if (r_state == S_DONE) begin
        r_err <= 1'b0;
      end
      case (r_state)
        S_MUL_INIT, S_DIV_INIT: r_cnt <= CNT_W'(N);
        S_SHIFT, S_DIV_CHK:     r_cnt <= r_cnt - CNT_W'(1);
        default:                r_cnt <= r_cnt;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.comp) begin
          case (bus.op)
            3'b010:  w_next = S_MUL_INIT;
            3'b011:  w_next = bus.b_zero ? S_DONE : S_DIV_INIT;
            default: w_next = S_EXEC;
          endcase
        end else if (bus.load) begin
          w_next = S_LDW;
        end else if (bus.clr) begin
          w_next = S_CLW;
        end
      end
      S_EXEC:     w_next = S_WB;
      S_WB:       w_next = S_DONE;
      S_MUL_INIT: w_next = S_ARITH;
      S_ARITH:    w_next = S_SHIFT;
      S_SHIFT:    w_next = w_last ? S_MWB : S_ARITH;
      S_DIV_INIT: w_next = S_DSHIFT;
      S_DSHIFT:   w_next = S_DSUB;
      S_DSUB:     w_next = S_DIV_CHK;
      S_DIV_CHK:  w_next = w_last ? S_MWB : S_DSHIFT;
      S_MWB:      w_next = S_DONE;
      S_DONE:     w_next = S_IDLE;
      S_LDW:      w_next = S_IDLE;
      S_CLW:      w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.we0     = 1'b0;
    bus.we1     = 1'b0;
    bus.src0    = 2'b00;
    bus.src1    = 2'b00;
    bus.alusrcA = 2'b00;
    bus.alusrcB = 2'b00;
    bus.alucntl = 3'b000;
    bus.AccSrc  = 1'b0;
    bus.QSrc    = 1'b0;
    bus.AccCntl = 1'b0;
    bus.Qcntl   = 1'b0;
    bus.shl     = 1'b0;
    bus.enable  = 1'b0;
    bus.reset_e = 1'b0;
    bus.qset    = 1'b0;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    bus.err     = 1'b0;
    if (!rst) begin
      bus.busy = (r_state != S_IDLE);
      case (r_state)
        S_EXEC: begin
          bus.alusrcA = 2'b01;
          bus.alusrcB = 2'b01;
          bus.alucntl = w_alu;
        end
        S_WB: begin
          bus.alucntl = w_alu;
          bus.src0    = 2'b01;
          bus.we0     = 1'b1;
          bus.we1     = 1'b1;
        end
        S_MUL_INIT, S_DIV_INIT: begin
          bus.AccCntl = 1'b1;
          bus.Qcntl   = 1'b1;
          bus.QSrc    = 1'b1;
          bus.reset_e = 1'b1;
        end
        S_ARITH: begin
          // Booth pair {Q0,Q-1}: 10 subtracts M, 01 adds M, 00/11 add zero.
          bus.alusrcA = 2'b10;
          bus.enable  = 1'b1;
          if ({bus.q0, bus.E} == 2'b10) begin
            bus.alusrcB = 2'b01;
            bus.alucntl = 3'b001;
          end else if ({bus.q0, bus.E} == 2'b01) begin
            bus.alusrcB = 2'b01;
          end
        end
        S_SHIFT, S_DSHIFT: begin
          bus.AccSrc  = 1'b1;
          bus.AccCntl = 1'b1;
          bus.Qcntl   = 1'b1;
          bus.shl     = (r_state == S_DSHIFT);
        end
        S_DSUB: begin
          bus.alusrcA = 2'b10;
          bus.alusrcB = 2'b01;
          bus.alucntl = 3'b001;
          bus.enable  = 1'b1;
        end
        S_DIV_CHK: begin
          if (bus.acc_neg) begin
            bus.alusrcA = 2'b10;
            bus.alusrcB = 2'b01;
            bus.enable  = 1'b1;
          end else begin
            bus.qset = 1'b1;
          end
        end
        S_MWB: begin
          bus.src0 = 2'b11;
          bus.src1 = 2'b11;
          bus.we0  = 1'b1;
          bus.we1  = 1'b1;
        end
        S_DONE: begin
          bus.done = 1'b1;
          bus.err  = r_err;
        end
        S_LDW: begin
          bus.src0 = 2'b10;
          bus.src1 = 2'b10;
          bus.we0  = 1'b1;
          bus.we1  = 1'b1;
        end
        S_CLW: begin
          bus.we0 = 1'b1;
          bus.we1 = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alp_seq_controller.sv
// Bench for alp_seq_controller: each operation is expanded into its expected per-cycle
// control trace from the operation rules, with random datapath flags and stray requests.
module tb_alp_seq_controller;
  localparam int N = 4;

  typedef struct packed {
    logic       we0;
    logic       we1;
    logic [1:0] src0;
    logic [1:0] src1;
    logic [1:0] alusrcA;
    logic [1:0] alusrcB;
    logic [2:0] alucntl;
    logic       AccSrc;
    logic       QSrc;
    logic       AccCntl;
    logic       Qcntl;
    logic       shl;
    logic       enable;
    logic       reset_e;
    logic       qset;
    logic       busy;
    logic       done;
    logic       err;
  } ov_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] dbg_state;
  int total = 0;
  int bad   = 0;

  // One entry per cycle: expected outputs and the {comp,load,clr,q0,E,acc_neg,b_zero} applied.
  logic [23:0] exp_q[$];
  logic [6:0]  in_q[$];

  alp_seq_controller_if bus();

  alp_seq_controller #(.N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .o_state (dbg_state)
  );

  always #5 clk = ~clk;

  function automatic ov_t observe();
    ov_t o;
    o = {bus.we0, bus.we1, bus.src0, bus.src1, bus.alusrcA, bus.alusrcB, bus.alucntl,
         bus.AccSrc, bus.QSrc, bus.AccCntl, bus.Qcntl, bus.shl, bus.enable,
         bus.reset_e, bus.qset, bus.busy, bus.done, bus.err};
    return o;
  endfunction

  task automatic check(input string tag, input ov_t expv);
    ov_t obs;
    obs = observe();
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h state=%0d", tag, obs, expv, dbg_state);
    end
  endtask

  task automatic apply(input logic [6:0] r);
    {bus.comp, bus.load, bus.clr, bus.q0, bus.E, bus.acc_neg, bus.b_zero} = r;
  endtask

  task automatic push(input ov_t e, input logic [6:0] r);
    exp_q.push_back(e);
    in_q.push_back(r);
  endtask

  // Builds the expected trace, issues the request and checks every cycle through the
  // following idle cycle. rst_at >= 0 asserts rst in that trace cycle instead.
  task automatic run_op(input string tag, input logic [2:0] opc, input logic bz,
                        input logic c, input logic ld, input logic cl, input int rst_at);
    ov_t        e;
    logic [6:0] r;
    logic       is_mul;
    logic [2:0] alu;
    exp_q.delete();
    in_q.delete();
    is_mul = (opc == 3'b010);
    alu    = (opc == 3'b111) ? 3'b011 : opc;
    if (c) begin
      if (opc == 3'b011 && bz) begin
        r = 7'($urandom); e = '0; e.busy = 1; e.done = 1; e.err = 1; push(e, r);
      end else if (opc == 3'b010 || opc == 3'b011) begin
        r = 7'($urandom); e = '0; e.busy = 1;
        e.AccCntl = 1; e.Qcntl = 1; e.QSrc = 1; e.reset_e = 1; push(e, r);
        for (int i = 0; i < N; i++) begin
          if (is_mul) begin
            r = 7'($urandom); e = '0; e.busy = 1; e.alusrcA = 2; e.enable = 1;
            case (r[3:2])
              2'b10:   begin e.alusrcB = 1; e.alucntl = 3'b001; end
              2'b01:   begin e.alusrcB = 1; e.alucntl = 3'b000; end
              default: begin e.alusrcB = 0; e.alucntl = 3'b000; end
            endcase
            push(e, r);
          end
          r = 7'($urandom); e = '0; e.busy = 1;
          e.AccSrc = 1; e.AccCntl = 1; e.Qcntl = 1; e.shl = !is_mul; push(e, r);
          if (!is_mul) begin
            r = 7'($urandom); e = '0; e.busy = 1;
            e.alusrcA = 2; e.alusrcB = 1; e.alucntl = 3'b001; e.enable = 1; push(e, r);
            r = 7'($urandom); e = '0; e.busy = 1;
            if (r[1]) begin e.alusrcA = 2; e.alusrcB = 1; e.alucntl = 0; e.enable = 1; end
            else e.qset = 1;
            push(e, r);
          end
        end
        r = 7'($urandom); e = '0; e.busy = 1; e.src0 = 3; e.src1 = 3; e.we0 = 1; e.we1 = 1;
        push(e, r);
        r = 7'($urandom); e = '0; e.busy = 1; e.done = 1; push(e, r);
      end else begin
        r = 7'($urandom); e = '0; e.busy = 1; e.alusrcA = 1; e.alusrcB = 1; e.alucntl = alu;
        push(e, r);
        r = 7'($urandom); e = '0; e.busy = 1; e.alucntl = alu; e.src0 = 1; e.we0 = 1; e.we1 = 1;
        push(e, r);
        r = 7'($urandom); e = '0; e.busy = 1; e.done = 1; push(e, r);
      end
    end else if (ld) begin
      r = 7'($urandom); e = '0; e.busy = 1; e.src0 = 2; e.src1 = 2; e.we0 = 1; e.we1 = 1;
      push(e, r);
    end else if (cl) begin
      r = 7'($urandom); e = '0; e.busy = 1; e.we0 = 1; e.we1 = 1; push(e, r);
    end

    bus.comp = c; bus.load = ld; bus.clr = cl; bus.op = opc; bus.b_zero = bz;
    bus.q0 = 1'($urandom); bus.E = 1'($urandom); bus.acc_neg = 1'($urandom);
    @(negedge clk);
    e = '0;
    check({tag, "_idle_req"}, e);
    @(posedge clk); #1;
    for (int i = 0; i < exp_q.size(); i++) begin
      apply(in_q[i]);
      if (i == rst_at) rst = 1'b1;
      @(negedge clk);
      if (i == rst_at) begin
        e = '0;
        check({tag, "_rst_cycle"}, e);
      end else begin
        check($sformatf("%s_c%0d", tag, i + 1), exp_q[i]);
      end
      @(posedge clk); #1;
      if (i == rst_at) begin
        rst = 1'b0;
        break;
      end
    end
    bus.comp = 1'b0; bus.load = 1'b0; bus.clr = 1'b0;
    @(negedge clk);
    e = '0;
    check({tag, "_after"}, e);
    @(posedge clk); #1;
  endtask

  initial begin
    ov_t z;
    z = '0;
    bus.comp = 1'b1; bus.load = 1'b1; bus.clr = 1'b1; bus.op = 3'b010;
    bus.E = 1'b1; bus.q0 = 1'b0; bus.acc_neg = 1'b1; bus.b_zero = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_hold", z);
    end
    @(posedge clk); #1;
    bus.comp = 1'b0; bus.load = 1'b0; bus.clr = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("reset_release", z);
    @(posedge clk); #1;

    run_op("add",  3'b000, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    run_op("sub",  3'b001, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    run_op("op7",  3'b111, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    run_op("op4",  3'b100, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    run_op("op5",  3'b101, 1'b1, 1'b1, 1'b0, 1'b0, -1);
    run_op("op6",  3'b110, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    for (int k = 0; k < 3; k++) run_op("mul", 3'b010, 1'($urandom), 1'b1, 1'b0, 1'b0, -1);
    for (int k = 0; k < 3; k++) run_op("div", 3'b011, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    run_op("divz", 3'b011, 1'b1, 1'b1, 1'b0, 1'b0, -1);
    run_op("prio_all",  3'b000, 1'b0, 1'b1, 1'b1, 1'b1, -1);
    run_op("prio_ldcl", 3'($urandom), 1'b0, 1'b0, 1'b1, 1'b1, -1);
    run_op("clr_only",  3'($urandom), 1'b0, 1'b0, 1'b0, 1'b1, -1);
    run_op("nothing",   3'($urandom), 1'b1, 1'b0, 1'b0, 1'b0, -1);
    run_op("mul_rst",   3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 2);
    run_op("mul_post",  3'b010, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    run_op("div_rst",   3'b011, 1'b0, 1'b1, 1'b0, 1'b0, 5);
    for (int k = 0; k < 25; k++) begin
      run_op("rnd", 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
